// File: rtl/flick_conditioner_pkg.sv
// Shared definitions for the flick push-button conditioner: FSM state
// encoding and default parameter values used by the RTL and the bench.
package flick_conditioner_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE   = 2'd0,
        CONFIRM_HIGH = 2'd1,
        HIGH_STABLE  = 2'd2,
        CONFIRM_LOW  = 2'd3
    } flick_state_e;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_CNT_W           = 3;

endpackage

// File: rtl/flick_sync.sv
// Parameterized N-stage reset-to-0 synchronizer for a single asynchronous
// level; also intended for reset pad synchronization.
module flick_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/flick_conditioner.sv
// Debounces the raw flick button into a clean synchronous level with
// registered rise/fall pulses and a glitch pulse for aborted transitions.
module flick_conditioner
    import flick_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flick_raw,
    output logic flick,
    output logic flick_rise,
    output logic flick_fall,
    output logic glitch
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > ((1 << CNT_W) - 1)) begin : g_bad_params
        $fatal(1, "flick_conditioner: illegal SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic s;

    flick_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(reset_n),
        .d    (flick_raw),
        .q    (s)
    );

    flick_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flick_q, flick_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;

    // s takes priority over the count, so a revert on the final confirm
    // sample aborts instead of committing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flick_d  = flick_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            LOW_STABLE: begin
                flick_d = 1'b0;
                if (s) begin
                    state_d = CONFIRM_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CONFIRM_HIGH: begin
                if (!s) begin
                    state_d  = LOW_STABLE;
                    glitch_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH_STABLE;
                    flick_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                flick_d = 1'b1;
                if (!s) begin
                    state_d = CONFIRM_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CONFIRM_LOW: begin
                if (s) begin
                    state_d  = HIGH_STABLE;
                    glitch_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW_STABLE;
                    flick_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW_STABLE;
                flick_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOW_STABLE;
            cnt_q    <= '0;
            flick_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flick_q  <= flick_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign flick      = flick_q;
    assign flick_rise = rise_q;
    assign flick_fall = fall_q;
    assign glitch     = glitch_q;

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed bench for flick_conditioner: reset, debounce latency, aborted
// transitions, continuous toggling and asynchronous reset mid-confirm.
module tb_flick_conditioner;
    import flick_conditioner_pkg::*;

    logic clk;
    logic reset_n;
    logic flick_raw;
    logic flick;
    logic flick_rise;
    logic flick_fall;
    logic glitch;

    int tests_run;
    int tests_failed;

    flick_conditioner #(
        .SYNC_STAGES    (DEFAULT_SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEFAULT_DEBOUNCE_CYCLES),
        .CNT_W          (DEFAULT_CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flick_raw (flick_raw),
        .flick     (flick),
        .flick_rise(flick_rise),
        .flick_fall(flick_fall),
        .glitch    (glitch)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one active edge, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ef, input logic er,
                              input logic efa, input logic eg);
        check_bit({tag, ".flick"},      flick,      ef);
        check_bit({tag, ".flick_rise"}, flick_rise, er);
        check_bit({tag, ".flick_fall"}, flick_fall, efa);
        check_bit({tag, ".glitch"},     glitch,     eg);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        flick_raw    = 1'b0;

        // reset state
        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // raw held low for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            check_outs("idle_low", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // press: flick rises after edge 6 with a single rise pulse
        flick_raw = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_outs("press_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("press_edge6", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_outs("press_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // low for 3 raw cycles: reverts on the final confirm sample
        flick_raw = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 3) flick_raw = 1'b1;
            check_outs("drop_abort_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("drop_abort_glitch", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_outs("drop_abort_after", 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // real release: flick falls after edge 6
        flick_raw = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_outs("release_wait", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("release_edge6", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outs("release_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // raw high for exactly 3 cycles: short pulse rejected
        flick_raw = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 3) flick_raw = 1'b0;
            check_outs("short_pulse_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("short_pulse_glitch", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_outs("short_pulse_after", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // toggle every cycle for 32 cycles: glitch on every even edge from 4
        flick_raw = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            flick_raw = ~flick_raw;
            check_outs("toggle", 1'b0, 1'b0, 1'b0, (k >= 4) && (k % 2 == 0));
        end
        flick_raw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_bit("toggle_settle.flick", flick, 1'b0);
        end
        tick();
        check_outs("toggle_settled", 1'b0, 1'b0, 1'b0, 1'b0);

        // async reset in CONFIRM_HIGH with cnt = 2, raw stays high
        flick_raw = 1'b1;
        repeat (4) tick();
        check_outs("pre_reset_confirm", 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("reset_in_confirm", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_outs("post_reset_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("post_reset_edge6", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("post_reset_hold", 1'b1, 1'b0, 1'b0, 1'b0);

        // async reset while flick is high and a release is pending
        flick_raw = 1'b0;
        repeat (4) tick();
        check_outs("pre_reset_high", 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("reset_while_high", 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_outs("post_reset_low", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/flick_conditioner.md
Name: flick_conditioner

Overview:
- Upstream stage of the bound-flasher control FSM.
- Takes the raw, asynchronous, bouncing `flick` push-button input and produces a clean, glitch-free, clock-synchronous `flick` level. The control FSM samples this level at its counter boundary points.
- Also produces one-cycle rise/fall pulses and a glitch-abort pulse for debug and coverage.
- Sits between the pad input and the control FSM's `flick` input.

Parameters:
- SYNC_STAGES, 2: number of metastability flops on `flick_raw`. Legal range 2..4.
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples needed to change the debounced level. Legal range 2..(2^CNT_W - 1).
- CNT_W, 3: width of the debounce counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flick_raw  in  1  raw button level, asynchronous to clk.
- flick  out  1  debounced level, registered. Drives the control FSM's `flick` input.
- flick_rise  out  1  one-cycle pulse in the cycle where `flick` goes 0->1.
- flick_fall  out  1  one-cycle pulse in the cycle where `flick` goes 1->0.
- glitch  out  1  one-cycle pulse when a pending level change is aborted.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset_n` is asynchronous and active-low.
- Reset state: all sync flops = 0, state = LOW_STABLE, cnt = 0, and flick = flick_rise = flick_fall = glitch = 0.
- Reset asserted mid-operation aborts any pending confirm with no pulse emitted.
- Synchronizer: a SYNC_STAGES-deep flop chain on `flick_raw`. The last stage, `s`, is the only signal the FSM uses.
- State machine: 4 states, all outputs registered.
  - LOW_STABLE:
    - s = 1 -> CONFIRM_HIGH, cnt <= 1.
    - Otherwise stay; `flick` held at 0.
  - CONFIRM_HIGH:
    - s = 0 -> LOW_STABLE, glitch <= 1, cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1 -> HIGH_STABLE, flick <= 1, flick_rise <= 1, cnt <= 0.
    - Else cnt <= cnt+1.
  - HIGH_STABLE:
    - s = 0 -> CONFIRM_LOW, cnt <= 1.
    - Otherwise stay; `flick` held at 1.
  - CONFIRM_LOW: mirror of CONFIRM_HIGH.
    - s = 1 -> HIGH_STABLE, glitch <= 1.
    - Else at cnt == DEBOUNCE_CYCLES-1 -> LOW_STABLE, flick <= 0, flick_fall <= 1.
- `flick` does not change during CONFIRM_* states. It holds its previous stable value.
- Latency:
  - Count the edge that first captures flick_raw = 1 as edge 1.
  - `flick` rises after edge SYNC_STAGES + DEBOUNCE_CYCLES; with defaults, after edge 6.
  - Release latency is the same.
- Boundary conditions:
  - s reverts on exactly the final confirm sample: abort. glitch pulses; no rise/fall pulse; flick unchanged.
  - flick_rise, flick_fall and glitch are mutually exclusive and each lasts exactly one cycle.
  - A raw pulse shorter than DEBOUNCE_CYCLES synchronized samples never changes `flick`.
  - Continuous toggling every cycle keeps `flick` constant indefinitely and pulses glitch every other cycle.
  - cnt never exceeds DEBOUNCE_CYCLES-1. No wrap is possible within the legal parameter range.
- Illegal states decode to LOW_STABLE with flick <= 0.
- Parameter legality is checked by an elaboration-time assertion in simulation.

Decomposition:
- Shared package:
  - 2-bit state localparams: LOW_STABLE = 0, CONFIRM_HIGH = 1, HIGH_STABLE = 2, CONFIRM_LOW = 3.
  - Default DEBOUNCE_CYCLES/SYNC_STAGES constants, so the top level and the bench agree.
- One sub-module: `flick_sync`, a parameterized N-stage reset-to-0 synchronizer, reusable for `reset_n` pad sync later.

Test Plan:
- Reset release, flick_raw held 0 for 20 cycles -> flick, flick_rise, flick_fall and glitch stay 0 throughout.
- flick_raw 0->1 captured at edge 1, held high (defaults) -> flick = 1 after edge 6; flick_rise high for exactly that one cycle; glitch never asserts.
- flick_raw high for exactly 3 cycles then low (defaults) -> flick stays 0; glitch pulses once; no flick_rise.
- From stable high, raw drops for 4 samples but returns high on the 4th sample -> flick stays 1; exactly one glitch pulse; no flick_fall.
- flick_raw toggles every cycle for 32 cycles -> flick constant; no rise/fall pulses.
- reset_n asserted asynchronously while in CONFIRM_HIGH with cnt = 2 -> all outputs 0 immediately. After release with raw still high, flick rises a full 6 edges later, not sooner.
